ahb_lite_simple_master: RTL and testbench
=========================================

Name: ahb_lite_simple_master

Overview:
- AHB-Lite initiator converting a valid/ready command stream into single AHB-Lite transfers.
- It is the requester side of the SDRAM/cache-backed AHB slave.
- Used by DMA-style engines (SD-card loader, test traffic generator) to read and write main memory over the same bus the harts use, including exclusive (LR/SC-style) access.
- Pipelined: the next address phase overlaps the current data phase.

Parameters:
W_ADDR, 32, address width
W_DATA, 32, data width (only 32 supported)
MASTER_ID, 8'h10, value driven on ahbls_hmaster; must differ from hart IDs

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  W_ADDR  byte address; caller guarantees natural alignment to cmd_size
cmd_size  in  3  HSIZE encoding, 0..2 only
cmd_wdata  in  W_DATA  write data, already lane-positioned
cmd_excl  in  1  exclusive access request
rsp_valid  out  1  one-cycle response pulse, one per command, in order
rsp_rdata  out  W_DATA  read data (0 for writes)
rsp_err  out  1  slave returned ERROR
rsp_exokay  out  1  sampled ahbls_hexokay for exclusive commands, else 0
ahbls_haddr  out  W_ADDR  address
ahbls_hwrite  out  1  direction
ahbls_htrans  out  2  IDLE(00)/NONSEQ(10) only
ahbls_hsize  out  3  size
ahbls_hburst  out  3  constant 3'b000 SINGLE
ahbls_hprot  out  4  constant 4'b0011
ahbls_hmastlock  out  1  constant 0
ahbls_hexcl  out  1  exclusive flag, address phase
ahbls_hmaster  out  8  MASTER_ID
ahbls_hwdata  out  W_DATA  data-phase write data
ahbls_hready  in  1  bus ready
ahbls_hresp  in  1  error response
ahbls_hexokay  in  1  exclusive OK, valid with hready in data phase
ahbls_hrdata  in  W_DATA  read data

Behaviour:
- Reset (async, rst_n low): htrans=IDLE, haddr=0, hwrite=0, hsize=0, hexcl=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_exokay=0, cmd_ready=1. All in-flight commands are dropped silently; no response is issued for them.
- Internal slots:
  - A (address phase): valid, addr, write, size, excl, wdata.
  - D (data phase): valid, write, excl, wdata.
- cmd_ready = !A.valid || (ahbls_hready && !(D.valid && ahbls_hresp)). This is combinational from hready.
- Accept: the command loads into A. From the next cycle htrans=NONSEQ and haddr/hwrite/hsize/hexcl come from A (registered outputs).
- A→D on posedge with hready=1 and A.valid, unless the error-cancel rule applies. The same edge may load a new command into A.
- ahbls_hwdata = D.wdata for the whole data phase.
- Data phase completes on posedge with hready=1 and D.valid. The next cycle produces:
  - rsp_valid=1;
  - rsp_rdata = hrdata for reads, 0 for writes;
  - rsp_err = hresp;
  - rsp_exokay = hexokay && D.excl && !hresp.
- Latency, zero wait states: accept edge N, address phase cycle N+1, data phase N+2, rsp_valid cycle N+3. Sustained throughput is 1 transfer/cycle.
- Wait states (hready=0): A and D hold. All bus outputs stay stable.
- Error (two-cycle): first cycle hresp=1, hready=0.
  - If A.valid, drive htrans=IDLE that cycle (cancel).
  - A is kept and re-issued as NONSEQ after the error completes.
  - cmd_ready=0 during the cancel cycle.
  - Second cycle hresp=1, hready=1: D completes with rsp_err=1.
- Exclusive: hexcl is driven only in the address phase. A failed exclusive write is reported as rsp_err=0, rsp_exokay=0. The block does no retry.
- htrans=IDLE whenever !A.valid. hburst, hprot and hmastlock are constant.
- SIM_MODE checks, each printing $display then $finish:
  - misaligned cmd_addr;
  - cmd_size>2;
  - hresp=1 while !D.valid.

Decomposition:
- Shared header (alongside define.vh), used by this block and the AHB slave:
  - HTRANS_IDLE/NONSEQ;
  - HSIZE_BYTE/HALF/WORD;
  - HBURST_SINGLE;
  - HPROT_DATA_PRIV constant.
- No sub-module. Single file with the A/D slot registers and output regs, roughly 150–250 lines.

Test Plan:
- Read, zero wait: cmd addr 0x0000_0100, slave returns 0xDEADBEEF → NONSEQ cycle N+1, rsp_valid cycle N+3, rsp_rdata=0xDEADBEEF, err=0.
- Write, 2 wait states: addr 0x104, size 2, data 0x12345678 → hwdata stable 3 cycles, rsp_valid 1 cycle after hready, rsp_rdata=0.
- Back-to-back: write 0x200 then read 0x200, cmd_valid held → second NONSEQ in the write's data-phase cycle, responses in order, read returns 0x12345678.
- Error: slave ERROR on read 0x300 with a pending read at 0x304 → htrans=IDLE in the first error cycle, rsp_err=1 for 0x300, 0x304 re-issued and completes err=0.
- Exclusive: excl read 0x400 (hexokay=1), excl write 0x400 (hexokay=1) → both rsp_exokay=1. Repeated excl write with hexokay=0 → rsp_exokay=0, err=0.
- Reset mid-transfer: rst_n low during a wait-stated data phase → all outputs at reset values immediately, no rsp_valid afterwards, new command after release runs normally.

Source files
------------

// File: rtl/ahb_lite_simple_master_pkg.sv
// Shared AHB-Lite encodings for the simple master and the matching slave.
// Also holds the alignment helper used by the simulation-only command checks.
package ahb_lite_simple_master_pkg;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;

  localparam logic [2:0] HSIZE_BYTE      = 3'b000;
  localparam logic [2:0] HSIZE_HALF      = 3'b001;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  function automatic logic addr_aligned(input logic [1:0] lsb, input logic [2:0] size);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = !lsb[0];
      HSIZE_WORD: ok = (lsb == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_lite_simple_master.sv
// AHB-Lite initiator: one valid/ready command becomes one SINGLE transfer, address phase of the
// next command overlapping the data phase of the current one; one in-order response pulse each.
module ahb_lite_simple_master
  import ahb_lite_simple_master_pkg::*;
#(
  parameter int          W_ADDR    = 32,
  parameter int          W_DATA    = 32,
  parameter logic [7:0]  MASTER_ID = 8'h10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [W_ADDR-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [W_DATA-1:0] cmd_wdata,
  input  logic              cmd_excl,
  output logic              rsp_valid,
  output logic [W_DATA-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_exokay,
  output logic [W_ADDR-1:0] ahbls_haddr,
  output logic              ahbls_hwrite,
  output logic [1:0]        ahbls_htrans,
  output logic [2:0]        ahbls_hsize,
  output logic [2:0]        ahbls_hburst,
  output logic [3:0]        ahbls_hprot,
  output logic              ahbls_hmastlock,
  output logic              ahbls_hexcl,
  output logic [7:0]        ahbls_hmaster,
  output logic [W_DATA-1:0] ahbls_hwdata,
  input  logic              ahbls_hready,
  input  logic              ahbls_hresp,
  input  logic              ahbls_hexokay,
  input  logic [W_DATA-1:0] ahbls_hrdata
);

  logic              a_vld_q, a_vld_d;
  logic [W_ADDR-1:0] a_addr_q, a_addr_d;
  logic              a_write_q, a_write_d;
  logic [2:0]        a_size_q, a_size_d;
  logic              a_excl_q, a_excl_d;
  logic [W_DATA-1:0] a_wdata_q, a_wdata_d;

  logic              d_vld_q, d_vld_d;
  logic              d_write_q, d_write_d;
  logic              d_excl_q, d_excl_d;
  logic [W_DATA-1:0] d_wdata_q, d_wdata_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [W_DATA-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_exokay_q, rsp_exokay_d;

  logic err_cancel, cmd_fire, a_advance, d_done;

  // Both ERROR cycles hold the pending address phase back as IDLE so the slave never samples it.
  assign err_cancel = d_vld_q && ahbls_hresp;
  assign cmd_ready  = !a_vld_q || (ahbls_hready && !err_cancel);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign a_advance  = a_vld_q && ahbls_hready && !err_cancel;
  assign d_done     = d_vld_q && ahbls_hready;

  always_comb begin
    a_vld_d   = a_vld_q;
    a_addr_d  = a_addr_q;
    a_write_d = a_write_q;
    a_size_d  = a_size_q;
    a_excl_d  = a_excl_q;
    a_wdata_d = a_wdata_q;
    d_vld_d   = d_vld_q;
    d_write_d = d_write_q;
    d_excl_d  = d_excl_q;
    d_wdata_d = d_wdata_q;

    if (a_advance) begin
      d_vld_d   = 1'b1;
      d_write_d = a_write_q;
      d_excl_d  = a_excl_q;
      d_wdata_d = a_wdata_q;
    end else if (d_done) begin
      d_vld_d   = 1'b0;
    end

    if (cmd_fire) begin
      a_vld_d   = 1'b1;
      a_addr_d  = cmd_addr;
      a_write_d = cmd_write;
      a_size_d  = cmd_size;
      a_excl_d  = cmd_excl;
      a_wdata_d = cmd_wdata;
    end else if (a_advance) begin
      a_vld_d   = 1'b0;
    end

    rsp_valid_d  = d_done;
    rsp_rdata_d  = (d_done && !d_write_q) ? ahbls_hrdata : '0;
    rsp_err_d    = d_done && ahbls_hresp;
    rsp_exokay_d = d_done && ahbls_hexokay && d_excl_q && !ahbls_hresp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q      <= 1'b0;
      a_addr_q     <= '0;
      a_write_q    <= 1'b0;
      a_size_q     <= 3'b000;
      a_excl_q     <= 1'b0;
      a_wdata_q    <= '0;
      d_vld_q      <= 1'b0;
      d_write_q    <= 1'b0;
      d_excl_q     <= 1'b0;
      d_wdata_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_exokay_q <= 1'b0;
    end else begin
      a_vld_q      <= a_vld_d;
      a_addr_q     <= a_addr_d;
      a_write_q    <= a_write_d;
      a_size_q     <= a_size_d;
      a_excl_q     <= a_excl_d;
      a_wdata_q    <= a_wdata_d;
      d_vld_q      <= d_vld_d;
      d_write_q    <= d_write_d;
      d_excl_q     <= d_excl_d;
      d_wdata_q    <= d_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      rsp_exokay_q <= rsp_exokay_d;
    end
  end

  assign ahbls_htrans    = (a_vld_q && !err_cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahbls_haddr     = a_addr_q;
  assign ahbls_hwrite    = a_write_q;
  assign ahbls_hsize     = a_size_q;
  assign ahbls_hexcl     = a_vld_q && a_excl_q && !err_cancel;
  assign ahbls_hwdata    = d_wdata_q;
  assign ahbls_hburst    = HBURST_SINGLE;
  assign ahbls_hprot     = HPROT_DATA_PRIV;
  assign ahbls_hmastlock = 1'b0;
  assign ahbls_hmaster   = MASTER_ID;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_exokay = rsp_exokay_q;

`ifdef SIM_MODE
  always @(posedge clk) begin
    if (rst_n) begin
      if (cmd_fire && cmd_size > HSIZE_WORD) begin
        $display("ahb_lite_simple_master: cmd_size %0d unsupported", cmd_size);
        $finish;
      end
      if (cmd_fire && !addr_aligned(cmd_addr[1:0], cmd_size)) begin
        $display("ahb_lite_simple_master: misaligned cmd_addr %h", cmd_addr);
        $finish;
      end
      if (ahbls_hresp && !d_vld_q) begin
        $display("ahb_lite_simple_master: hresp asserted with no data phase");
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ahb_lite_simple_master.sv
// Directed bench: a scripted AHB-Lite slave, a response scoreboard fed at command acceptance,
// and a monitor that pops and compares on every rsp_valid pulse.
module tb_ahb_lite_simple_master;
  import ahb_lite_simple_master_pkg::*;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_excl;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err, rsp_exokay;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hmastlock, hexcl, hready, hresp, hexokay;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [7:0]  hmaster;

  ahb_lite_simple_master #(.W_ADDR(32), .W_DATA(32), .MASTER_ID(8'h10)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata), .cmd_excl(cmd_excl),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_exokay(rsp_exokay),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans), .ahbls_hsize(hsize),
    .ahbls_hburst(hburst), .ahbls_hprot(hprot), .ahbls_hmastlock(hmastlock),
    .ahbls_hexcl(hexcl), .ahbls_hmaster(hmaster), .ahbls_hwdata(hwdata),
    .ahbls_hready(hready), .ahbls_hresp(hresp), .ahbls_hexokay(hexokay), .ahbls_hrdata(hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] rdata; logic err; logic exok; } rsp_t;
  typedef struct { int waits; bit err; bit exok; } plan_t;

  rsp_t        sb[$];
  plan_t       plans[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Slave model: samples the bus at negedge, updates its drive just after posedge.
  bit          dp_active, dp_write, s_take, s_done, t_write;
  logic [31:0] dp_addr, t_addr, t_wdata;
  int          dp_cnt;
  plan_t       dp_plan;

  initial begin
    hready = 1'b1; hresp = 1'b0; hexokay = 1'b0; hrdata = '0;
    dp_active = 1'b0; dp_write = 1'b0; dp_addr = '0; dp_cnt = 0; dp_plan = '{0, 1'b0, 1'b0};
    forever begin
      @(negedge clk);
      s_take  = rst_n && (htrans == HTRANS_NONSEQ) && hready;
      s_done  = rst_n && dp_active && hready;
      t_addr  = haddr;
      t_write = hwrite;
      t_wdata = hwdata;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        dp_active = 1'b0;
      end else begin
        if (s_done) begin
          dp_active = 1'b0;
          if (dp_write && !dp_plan.err) mem[dp_addr] = t_wdata;
        end
        if (s_take) begin
          dp_active = 1'b1;
          dp_addr   = t_addr;
          dp_write  = t_write;
          dp_cnt    = 0;
          if (plans.size() > 0) dp_plan = plans.pop_front();
          else dp_plan = '{0, 1'b0, 1'b0};
        end else if (dp_active) begin
          dp_cnt++;
        end
      end
      hready = 1'b1; hresp = 1'b0; hexokay = 1'b0; hrdata = '0;
      if (dp_active) begin
        if (dp_plan.err) begin
          if (dp_cnt < dp_plan.waits) hready = 1'b0;
          else if (dp_cnt == dp_plan.waits) begin hready = 1'b0; hresp = 1'b1; end
          else hresp = 1'b1;
        end else if (dp_cnt < dp_plan.waits) begin
          hready = 1'b0;
        end else begin
          hexokay = dp_plan.exok;
          if (!dp_write) hrdata = mem.exists(dp_addr) ? mem[dp_addr] : 32'h0;
        end
      end
    end
  end

  // Response monitor
  rsp_t got_r, exp_r;
  int   rsp_idx = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        checks++;
        got_r = {rsp_rdata, rsp_err, rsp_exokay};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected #%0d rdata %h err %b exok %b, none expected",
                   rsp_idx, rsp_rdata, rsp_err, rsp_exokay);
        end else begin
          exp_r = sb.pop_front();
          if (got_r !== exp_r) begin
            errors++;
            $display("FAIL rsp#%0d rdata %h err %b exok %b, expected rdata %h err %b exok %b",
                     rsp_idx, got_r.rdata, got_r.err, got_r.exok, exp_r.rdata, exp_r.err, exp_r.exok);
          end
        end
        rsp_idx++;
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, input bit ex,
                       input logic [31:0] e_rdata, input bit e_err, input bit e_exok);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
      cmd_size = size; cmd_wdata = wd; cmd_excl = ex;
      if (cmd_ready) acc = 1'b1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout addr %h cmd_ready %b required 1", addr, cmd_ready);
    end
    @(posedge clk);
    #1;
    if (acc) sb.push_back({e_rdata, e_err, e_exok});
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_htrans"},   32'(htrans), 32'(HTRANS_IDLE));
    check({tag, "_haddr"},    haddr, 32'h0);
    check({tag, "_hwrite"},   32'(hwrite), 32'h0);
    check({tag, "_hsize"},    32'(hsize), 32'h0);
    check({tag, "_hexcl"},    32'(hexcl), 32'h0);
    check({tag, "_hwdata"},   hwdata, 32'h0);
    check({tag, "_rsp_vld"},  32'(rsp_valid), 32'h0);
    check({tag, "_rsp_data"}, rsp_rdata, 32'h0);
    check({tag, "_cmd_rdy"},  32'(cmd_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = 3'd0; cmd_wdata = '0; cmd_excl = 1'b0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h304] = 32'hCAFEF00D;
    mem[32'h400] = 32'h55AA55AA;
    #1;
    check_reset_outputs("reset");
    check("hburst", 32'(hburst), 32'h0);
    check("hprot", 32'(hprot), 32'h3);
    check("hmaster", 32'(hmaster), 32'h10);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read, zero wait states
    plans.push_back('{0, 1'b0, 1'b0});
    issue(1'b0, 32'h100, HSIZE_WORD, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("t1_htrans_aph", 32'(htrans), 32'(HTRANS_NONSEQ));
    check("t1_haddr", haddr, 32'h100);
    @(negedge clk);
    check("t1_rsp_early", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check("t1_rsp_lat", 32'(rsp_valid), 32'h1);
    repeat (3) @(negedge clk);

    // Write, two wait states
    plans.push_back('{2, 1'b0, 1'b0});
    issue(1'b1, 32'h104, HSIZE_WORD, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("t2_hwrite", 32'(hwrite), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t2_hwdata_%0d", i), hwdata, 32'h12345678);
      check($sformatf("t2_rsp_hold_%0d", i), 32'(rsp_valid), 32'h0);
    end
    @(negedge clk);
    check("t2_rsp_lat", 32'(rsp_valid), 32'h1);
    repeat (3) @(negedge clk);

    // Back-to-back write then read of the same word
    plans.push_back('{0, 1'b0, 1'b0});
    plans.push_back('{0, 1'b0, 1'b0});
    issue(1'b1, 32'h200, HSIZE_WORD, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h200, HSIZE_WORD, 32'h0, 1'b0, 32'h12345678, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("t3_htrans_overlap", 32'(htrans), 32'(HTRANS_NONSEQ));
    check("t3_hwrite_read", 32'(hwrite), 32'h0);
    check("t3_hwdata_overlap", hwdata, 32'h12345678);
    repeat (4) @(negedge clk);

    // Error on 0x300 with 0x304 queued behind it
    plans.push_back('{0, 1'b1, 1'b0});
    plans.push_back('{0, 1'b0, 1'b0});
    issue(1'b0, 32'h300, HSIZE_WORD, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 32'h304, HSIZE_WORD, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("t4_htrans_cancel", 32'(htrans), 32'(HTRANS_IDLE));
    check("t4_cmd_ready_cancel", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t4_reissue_htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
    check("t4_reissue_haddr", haddr, 32'h304);
    repeat (4) @(negedge clk);

    // Exclusive read, exclusive write, failed exclusive write
    plans.push_back('{0, 1'b0, 1'b1});
    issue(1'b0, 32'h400, HSIZE_WORD, 32'h0, 1'b1, 32'h55AA55AA, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("t5_hexcl_aph", 32'(hexcl), 32'h1);
    @(negedge clk);
    check("t5_hexcl_dph", 32'(hexcl), 32'h0);
    repeat (3) @(negedge clk);
    plans.push_back('{0, 1'b0, 1'b1});
    issue(1'b1, 32'h400, HSIZE_WORD, 32'h0BADF00D, 1'b1, 32'h0, 1'b0, 1'b1);
    idle();
    repeat (4) @(negedge clk);
    plans.push_back('{0, 1'b0, 1'b0});
    issue(1'b1, 32'h400, HSIZE_WORD, 32'h0BADF00D, 1'b1, 32'h0, 1'b0, 1'b0);
    idle();
    repeat (4) @(negedge clk);

    // Reset during a wait-stated data phase
    plans.push_back('{5, 1'b0, 1'b0});
    issue(1'b1, 32'h500, HSIZE_WORD, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    check("t6_in_wait", 32'(hready), 32'h0);
    rst_n = 1'b0;
    sb.delete();
    plans.delete();
    #1;
    check_reset_outputs("t6_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_no_write", 32'(mem.exists(32'h500)), 32'h0);
    plans.push_back('{0, 1'b0, 1'b0});
    issue(1'b0, 32'h100, HSIZE_WORD, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("t6_post_htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
    repeat (4) @(negedge clk);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    check("mem_0x400", mem[32'h400], 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
